// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, opcodes, flag indices and memory-stage state encoding.
package pipe_pkg;

   localparam int unsigned DW        = 16;
   localparam int unsigned OPW       = 6;
   localparam int unsigned FW        = 2;
   localparam int unsigned FLAG_OVF  = 0;
   localparam int unsigned FLAG_ZERO = 1;

   localparam logic [OPW-1:0] OP_LD = 6'b010100;
   localparam logic [OPW-1:0] OP_ST = 6'b010101;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   // True for ops that need a data-memory transaction.
   function automatic logic is_mem_op(input logic [OPW-1:0] op);
      return (op == OP_LD) || (op == OP_ST);
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for an outstanding memory request; expired flags the last allowed cycle.
module mem_timeout_ctr #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CW      = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: passes ALU results to writeback and runs req/ack load/store transactions with timeout.
module mem_access_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DW      = pipe_pkg::DW,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CW      = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          valid_ex,
   input  logic [5:0]    op_ex,
   input  logic [DW-1:0] ans_ex,
   input  logic [DW-1:0] DM_data,
   input  logic [1:0]    flag_ex,
   output logic          stall,
   output logic          dm_req,
   output logic          dm_we,
   output logic [DW-1:0] dm_addr,
   output logic [DW-1:0] dm_wdata,
   input  logic [DW-1:0] dm_rdata,
   input  logic          dm_ack,
   output logic          wb_valid,
   output logic [5:0]    wb_op,
   output logic [DW-1:0] wb_data,
   output logic [1:0]    wb_flag,
   output logic          wb_err
);

   state_t     state;
   logic [5:0] op_q;
   logic [1:0] flag_q;
   logic [1:0] ld_flag;
   logic       capture;
   logic       ctr_en;
   logic       expired;

   assign capture = (state == IDLE) && valid_ex && is_mem_op(op_ex);
   assign ctr_en  = (state == REQ) && !dm_ack && !expired;
   assign stall   = (state != IDLE);

   // Loads report zero-result; overflow is meaningless for memory data.
   always_comb begin
      ld_flag            = '0;
      ld_flag[FLAG_ZERO] = (dm_rdata == '0);
   end

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (capture),
      .enable  (ctr_en),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= '0;
         flag_q   <= '0;
         dm_req   <= 1'b0;
         dm_we    <= 1'b0;
         dm_addr  <= '0;
         dm_wdata <= '0;
         wb_valid <= 1'b0;
         wb_op    <= '0;
         wb_data  <= '0;
         wb_flag  <= '0;
         wb_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!valid_ex) begin
                  wb_valid <= 1'b0;
               end else if (is_mem_op(op_ex)) begin
                  dm_addr  <= ans_ex;
                  dm_wdata <= DM_data;
                  dm_we    <= (op_ex == OP_ST);
                  dm_req   <= 1'b1;
                  op_q     <= op_ex;
                  flag_q   <= flag_ex;
                  wb_valid <= 1'b0;
                  state    <= REQ;
               end else begin
                  wb_valid <= 1'b1;
                  wb_data  <= ans_ex;
                  wb_op    <= op_ex;
                  wb_flag  <= flag_ex;
                  wb_err   <= 1'b0;
               end
            end
            REQ: begin
               // An ack in the final cycle still completes normally.
               if (dm_ack) begin
                  dm_req   <= 1'b0;
                  dm_we    <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_err   <= 1'b0;
                  wb_op    <= op_q;
                  state    <= IDLE;
                  if (op_q == OP_LD) begin
                     wb_data <= dm_rdata;
                     wb_flag <= ld_flag;
                  end else begin
                     wb_data <= dm_addr;
                     wb_flag <= flag_q;
                  end
               end else if (expired) begin
                  dm_req   <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_err   <= 1'b1;
                  wb_data  <= '0;
                  wb_op    <= op_q;
                  wb_flag  <= flag_q;
                  state    <= IDLE;
               end else begin
                  wb_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table-driven pass-through plus load/store/timeout/reset sequences.
module tb_mem_access_stage;

   localparam logic [5:0] LD = 6'b010100;
   localparam logic [5:0] ST = 6'b010101;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_ex;
   logic [5:0]  op_ex;
   logic [15:0] ans_ex;
   logic [15:0] DM_data;
   logic [1:0]  flag_ex;
   logic        stall;
   logic        dm_req;
   logic        dm_we;
   logic [15:0] dm_addr;
   logic [15:0] dm_wdata;
   logic [15:0] dm_rdata;
   logic        dm_ack;
   logic        wb_valid;
   logic [5:0]  wb_op;
   logic [15:0] wb_data;
   logic [1:0]  wb_flag;
   logic        wb_err;

   int n_tests = 0;
   int n_fail  = 0;

   mem_access_stage dut (
      .clk      (clk),
      .reset    (reset),
      .valid_ex (valid_ex),
      .op_ex    (op_ex),
      .ans_ex   (ans_ex),
      .DM_data  (DM_data),
      .flag_ex  (flag_ex),
      .stall    (stall),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_rdata (dm_rdata),
      .dm_ack   (dm_ack),
      .wb_valid (wb_valid),
      .wb_op    (wb_op),
      .wb_data  (wb_data),
      .wb_flag  (wb_flag),
      .wb_err   (wb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [5:0]  op;
      logic [15:0] ans;
      logic [1:0]  flag;
      logic        exp_valid;
      logic [15:0] exp_data;
      logic [1:0]  exp_flag;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [1:0] fl);
      valid_ex = 1'b1;
      op_ex    = op;
      ans_ex   = addr;
      DM_data  = wd;
      flag_ex  = fl;
      step();
   endtask

   initial begin
      vecs[0] = '{1'b1, 6'b000000, 16'h1234, 2'b01, 1'b1, 16'h1234, 2'b01};
      vecs[1] = '{1'b1, 6'b000000, 16'h1234, 2'b01, 1'b1, 16'h1234, 2'b01};
      vecs[2] = '{1'b1, 6'b000000, 16'h1234, 2'b01, 1'b1, 16'h1234, 2'b01};
      vecs[3] = '{1'b1, 6'b010110, 16'h8001, 2'b10, 1'b1, 16'h8001, 2'b10};
      vecs[4] = '{1'b1, 6'b111111, 16'hFFFF, 2'b11, 1'b1, 16'hFFFF, 2'b11};
      vecs[5] = '{1'b0, 6'b000001, 16'h5555, 2'b00, 1'b0, 16'hFFFF, 2'b11};
      vecs[6] = '{1'b1, 6'b010011, 16'h0000, 2'b00, 1'b1, 16'h0000, 2'b00};

      reset = 1'b1; valid_ex = 1'b0; op_ex = '0; ans_ex = '0; DM_data = '0;
      flag_ex = '0; dm_rdata = '0; dm_ack = 1'b0;
      step();
      step();
      chk("rst_stall", 32'(stall), 32'(0));
      chk("rst_dm_req", 32'(dm_req), 32'(0));
      chk("rst_wb_valid", 32'(wb_valid), 32'(0));
      chk("rst_wb_err", 32'(wb_err), 32'(0));
      chk("rst_dm_addr", 32'(dm_addr), 32'(0));
      chk("rst_wb_data", 32'(wb_data), 32'(0));
      reset = 1'b0;

      // Pass-through table
      for (int i = 0; i < 7; i++) begin
         valid_ex = vecs[i].valid;
         op_ex    = vecs[i].op;
         ans_ex   = vecs[i].ans;
         flag_ex  = vecs[i].flag;
         step();
         chk($sformatf("pt%0d_valid", i), 32'(wb_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("pt%0d_data", i), 32'(wb_data), 32'(vecs[i].exp_data));
         chk($sformatf("pt%0d_flag", i), 32'(wb_flag), 32'(vecs[i].exp_flag));
         chk($sformatf("pt%0d_stall", i), 32'(stall), 32'(0));
         chk($sformatf("pt%0d_dm_req", i), 32'(dm_req), 32'(0));
         if (vecs[i].exp_valid) begin
            chk($sformatf("pt%0d_op", i), 32'(wb_op), 32'(vecs[i].op));
            chk($sformatf("pt%0d_err", i), 32'(wb_err), 32'(0));
         end
      end

      // Load, ack in third REQ cycle
      issue(LD, 16'h0040, 16'h7777, 2'b11);
      chk("ld_req", 32'(dm_req), 32'(1));
      chk("ld_addr", 32'(dm_addr), 32'h0040);
      chk("ld_we", 32'(dm_we), 32'(0));
      chk("ld_stall0", 32'(stall), 32'(1));
      chk("ld_wbv0", 32'(wb_valid), 32'(0));
      for (int i = 1; i <= 2; i++) begin
         step();
         chk($sformatf("ld_stall%0d", i), 32'(stall), 32'(1));
         chk($sformatf("ld_req%0d", i), 32'(dm_req), 32'(1));
         chk($sformatf("ld_wbv%0d", i), 32'(wb_valid), 32'(0));
      end
      valid_ex = 1'b0; dm_ack = 1'b1; dm_rdata = 16'hBEEF;
      step();
      dm_ack = 1'b0;
      chk("ld_done_valid", 32'(wb_valid), 32'(1));
      chk("ld_done_data", 32'(wb_data), 32'hBEEF);
      chk("ld_done_flag", 32'(wb_flag), 32'(2'b00));
      chk("ld_done_op", 32'(wb_op), 32'(LD));
      chk("ld_done_err", 32'(wb_err), 32'(0));
      chk("ld_done_stall", 32'(stall), 32'(0));
      chk("ld_done_req", 32'(dm_req), 32'(0));
      step();
      chk("ld_after_valid", 32'(wb_valid), 32'(0));

      // Store with immediate ack
      issue(ST, 16'h0010, 16'hA5A5, 2'b11);
      chk("st_we", 32'(dm_we), 32'(1));
      chk("st_wdata", 32'(dm_wdata), 32'hA5A5);
      chk("st_addr", 32'(dm_addr), 32'h0010);
      chk("st_wbv0", 32'(wb_valid), 32'(0));
      valid_ex = 1'b0; dm_ack = 1'b1; dm_rdata = 16'h9999;
      step();
      dm_ack = 1'b0;
      chk("st_done_valid", 32'(wb_valid), 32'(1));
      chk("st_done_data", 32'(wb_data), 32'h0010);
      chk("st_done_flag", 32'(wb_flag), 32'(2'b11));
      chk("st_done_err", 32'(wb_err), 32'(0));
      chk("st_done_we", 32'(dm_we), 32'(0));
      chk("st_done_op", 32'(wb_op), 32'(ST));

      // Load of zero, plus an ack while IDLE that must be ignored
      dm_ack = 1'b1;
      step();
      dm_ack = 1'b0;
      chk("idle_ack_valid", 32'(wb_valid), 32'(0));
      chk("idle_ack_stall", 32'(stall), 32'(0));
      issue(LD, 16'h0022, 16'h0000, 2'b01);
      valid_ex = 1'b0; dm_ack = 1'b1; dm_rdata = 16'h0000;
      step();
      dm_ack = 1'b0;
      chk("ldz_valid", 32'(wb_valid), 32'(1));
      chk("ldz_data", 32'(wb_data), 32'(0));
      chk("ldz_flag", 32'(wb_flag), 32'(2'b10));

      // Timeout without ack: dm_req high 15 cycles
      issue(LD, 16'h0080, 16'h0000, 2'b00);
      chk("to_req0", 32'(dm_req), 32'(1));
      valid_ex = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         step();
         chk($sformatf("to_req%0d", i), 32'(dm_req), 32'(1));
         chk($sformatf("to_wbv%0d", i), 32'(wb_valid), 32'(0));
      end
      step();
      chk("to_abort_req", 32'(dm_req), 32'(0));
      chk("to_abort_valid", 32'(wb_valid), 32'(1));
      chk("to_abort_err", 32'(wb_err), 32'(1));
      chk("to_abort_data", 32'(wb_data), 32'(0));
      chk("to_abort_stall", 32'(stall), 32'(0));
      step();
      chk("to_after_valid", 32'(wb_valid), 32'(0));
      chk("to_after_stall", 32'(stall), 32'(0));

      // Ack arrives in the 15th REQ cycle: normal completion
      issue(LD, 16'h0090, 16'h0000, 2'b00);
      valid_ex = 1'b0;
      for (int i = 1; i <= 14; i++) step();
      chk("to15_req", 32'(dm_req), 32'(1));
      dm_ack = 1'b1; dm_rdata = 16'h1234;
      step();
      dm_ack = 1'b0;
      chk("to15_valid", 32'(wb_valid), 32'(1));
      chk("to15_err", 32'(wb_err), 32'(0));
      chk("to15_data", 32'(wb_data), 32'h1234);

      // Reset in REQ cycle 2, then a late ack
      issue(ST, 16'h0100, 16'hCAFE, 2'b00);
      valid_ex = 1'b0;
      step();
      chk("rq_stall", 32'(stall), 32'(1));
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rq_req", 32'(dm_req), 32'(0));
      chk("rq_stall_after", 32'(stall), 32'(0));
      chk("rq_valid", 32'(wb_valid), 32'(0));
      dm_ack = 1'b1;
      step();
      dm_ack = 1'b0;
      chk("rq_late_ack_valid", 32'(wb_valid), 32'(0));
      chk("rq_late_ack_stall", 32'(stall), 32'(0));

      // Pass-through resumes after reset
      issue(6'b000010, 16'h4242, 16'h0000, 2'b10);
      chk("post_valid", 32'(wb_valid), 32'(1));
      chk("post_data", 32'(wb_data), 32'h4242);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 16-bit pipeline; the consumer of the execute stage's registered outputs (result/address, store data, decoded op).
- Non-memory ops pass through to writeback in one cycle.
- Loads and stores run a request/acknowledge transaction to data memory and stall the execute stage until the transaction completes or times out.

Parameters:
- DW, 16, data/address width
- TIMEOUT, 15, max cycles in REQ without dm_ack before abort (>=1)
- CW, 4, timeout counter width (2^CW > TIMEOUT)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- valid_ex  in  1  execute-stage outputs hold a live instruction
- op_ex  in  6  decoded opcode accompanying the execute result
- ans_ex  in  DW  execute result; memory address for LD/ST
- DM_data  in  DW  store data
- flag_ex  in  2  execute flags {zero, overflow}
- stall  out  1  hold execute stage; equals (state != IDLE)
- dm_req  out  1  memory request, registered
- dm_we  out  1  1 = write, registered
- dm_addr  out  DW  registered address
- dm_wdata  out  DW  registered store data
- dm_rdata  in  DW  read data, valid with dm_ack
- dm_ack  in  1  one-cycle completion strobe
- wb_valid  out  1  one-cycle pulse, result for writeback
- wb_op  out  6  opcode of the retiring instruction
- wb_data  out  DW  writeback value
- wb_flag  out  2  flags of the retiring instruction
- wb_err  out  1  pulses with wb_valid on timeout abort

Behaviour:
- Reset (sync, high): state=IDLE, counter=0; all outputs 0, including stall, dm_req, wb_valid and wb_err. Reset mid-transaction drops dm_req at that edge; a late dm_ack is ignored.
- Op classes: OP_LD=6'b010100 (load); OP_ST=6'b010101 (store); every other op is pass-through.
- IDLE, valid_ex=0: wb_valid<=0; no other change.
- IDLE, valid_ex=1, pass-through op: next edge sets wb_valid<=1, wb_data<=ans_ex, wb_op<=op_ex, wb_flag<=flag_ex, wb_err<=0. State stays IDLE. Latency 1, back-to-back every cycle.
- IDLE, valid_ex=1, LD/ST: next edge sets dm_addr<=ans_ex, dm_wdata<=DM_data, dm_we<=(op==OP_ST), dm_req<=1, and latches op/flags. Counter<=0, state<=REQ, wb_valid<=0.
- REQ, stall=1:
  - dm_ack=1: dm_req<=0, dm_we<=0, wb_valid<=1, wb_err<=0, state<=IDLE. LD sets wb_data<=dm_rdata and wb_flag<={dm_rdata==0, 0}. ST sets wb_data<=dm_addr and wb_flag<=latched flags.
  - no ack, counter==TIMEOUT-1: abort. dm_req<=0, wb_valid<=1, wb_err<=1, wb_data<=0, state<=IDLE.
  - otherwise: counter++.
  - ack and timeout in the same cycle: ack wins, no error.
- Minimum memory-op latency: 2 edges from capture to wb_valid (ack in the first REQ cycle).
- dm_ack while IDLE is ignored.
- valid_ex is not sampled while in REQ; the upstream stage holds its outputs under stall.
- dm_addr/dm_wdata hold their values while dm_req=1.

Decomposition:
- Shared package pipe_pkg: DW, opcode constants OP_LD/OP_ST (extended later with other opcodes), state enum {IDLE, REQ}, flag bit indices FLAG_OVF=0, FLAG_ZERO=1.
- One sub-module, mem_timeout_ctr: clear, enable, expired output at TIMEOUT-1. The FSM and datapath stay in the top module.

Test Plan:
- Pass-through: op_ex=6'b000000, ans_ex=16'h1234, flag_ex=2'b01, valid_ex=1 for 3 cycles -> wb_valid=1 each following cycle, wb_data=16'h1234, wb_flag=2'b01, stall=0 throughout.
- Load, ack after 3 REQ cycles, dm_rdata=16'hBEEF: op=LD, ans_ex=16'h0040 -> dm_req=1 with dm_addr=16'h0040, dm_we=0; stall=1 for 3 cycles; then wb_valid pulse with wb_data=16'hBEEF, wb_flag=2'b00.
- Store, immediate ack: op=ST, ans_ex=16'h0010, DM_data=16'hA5A5 -> dm_we=1, dm_wdata=16'hA5A5; wb_valid 2 edges after capture with wb_data=16'h0010, wb_err=0.
- Load of zero: dm_rdata=16'h0000 with ack -> wb_flag=2'b10.
- Timeout (TIMEOUT=15), no ack -> dm_req high 15 cycles, then drops; wb_valid=1, wb_err=1, wb_data=0; stall low the next cycle. Repeat with ack in cycle 15 -> wb_err=0, normal completion.
- Reset mid-REQ: assert reset in cycle 2 of REQ -> next edge dm_req=0, stall=0, wb_valid=0; a dm_ack in the following cycle produces no wb_valid.
